// File: rtl/parameters.sv
// rtl/parameters.sv - shared widths, precision encodings and packer state type
package parameters;

  localparam int ACC_DATA_WIDTH = 32;
  localparam int ACT_DATA_WIDTH = 8;

  localparam logic [1:0] PREC_8B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_2B = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } packer_state_t;

  // Encoding 3 is reserved and behaves as 4-bit.
  function automatic int elem_width(input logic [1:0] prec);
    case (prec)
      PREC_8B: return 8;
      PREC_2B: return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/packer_word_fifo.sv
// rtl/packer_word_fifo.sv - synchronous FIFO of packed words with strobes and last flag
//
// Purpose: holds closed words between the packer and the L1 write port.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   push_valid/data/strb/last  write side; push ignored when full
//   pop_ready               consumer takes the head word when pop_valid
//   pop_valid/data/strb/last   head word, driven straight from storage flops
//   full                    no free entry
module packer_word_fifo #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid,
  input  logic [WORD_WIDTH-1:0]   push_data,
  input  logic [WORD_WIDTH/8-1:0] push_strb,
  input  logic                    push_last,
  input  logic                    pop_ready,
  output logic                    pop_valid,
  output logic [WORD_WIDTH-1:0]   pop_data,
  output logic [WORD_WIDTH/8-1:0] pop_strb,
  output logic                    pop_last,
  output logic                    full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WORD_WIDTH-1:0]   data_mem [DEPTH];
  logic [WORD_WIDTH/8-1:0] strb_mem [DEPTH];
  logic                    last_mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    do_push;
  logic                    do_pop;

  assign full      = (count == CNT_MAX);
  assign pop_valid = (count != '0);
  assign do_push   = push_valid & ~full;
  assign do_pop    = pop_ready & pop_valid;

  // Storage is cleared on reset so the head outputs read as zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        strb_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        strb_mem[wr_ptr] <= push_strb;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = data_mem[rd_ptr];
  assign pop_strb = strb_mem[rd_ptr];
  assign pop_last = last_mem[rd_ptr];

endmodule

// File: rtl/pe_output_packer.sv
// rtl/pe_output_packer.sv - packs PE output activations into 8/4/2-bit-lane words
//
// Purpose: takes one saturated activation per cycle from a PE output lane, keeps its
// low E bits (E = 8/4/2 by PRECISION) and packs them LSB-first into WORD_WIDTH words.
// A word closes when full or on in_last; closed words queue in a small FIFO.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   PRECISION          0=8b, 1=4b, 2=2b, 3=4b; sampled at the first element of a word
//   in_valid/in_ready  element handshake; in_ready depends only on FIFO occupancy
//   in_data, in_last   element value (low E bits used), row/tile end marker
//   out_valid/out_ready  packed word handshake
//   out_data/out_strb/out_last  packed word, byte enables, row/tile close flag
//   busy               partial word pending or FIFO not empty
module pe_output_packer #(
  parameter int ACC_DATA_WIDTH = parameters::ACC_DATA_WIDTH,
  parameter int ACT_DATA_WIDTH = parameters::ACT_DATA_WIDTH,
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                PRECISION,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_DATA_WIDTH-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_WIDTH-1:0]     out_data,
  output logic [WORD_WIDTH/8-1:0]   out_strb,
  output logic                      out_last,
  output logic                      busy
);

  import parameters::*;

  // fill must reach the element count of the narrowest (2-bit) packing.
  localparam int FW = $clog2(WORD_WIDTH / 2 + 1);
  localparam logic [FW-1:0] FILL_ONE = 1;

  packer_state_t state;
  packer_state_t state_next;

  logic [FW-1:0]           fill;
  logic [1:0]              prec_q;
  logic [WORD_WIDTH-1:0]   word_q;
  logic [WORD_WIDTH-1:0]   word_next;
  logic [WORD_WIDTH/8-1:0] strb_next;
  logic                    accept;
  logic                    word_close;
  logic                    fifo_full;

  logic unused_in_data_hi;
  assign unused_in_data_hi = &{1'b0, in_data[ACC_DATA_WIDTH-1:ACT_DATA_WIDTH]};

  assign in_ready = ~fifo_full;
  assign accept   = in_valid & in_ready;

  // Datapath: the first element of a word uses the live PRECISION, later ones the
  // latched copy, so a mid-word precision change only takes effect on the next word.
  always_comb begin
    int                      e_w;
    int                      n_el;
    int                      fill_i;
    int                      used_bits;
    logic [1:0]              prec_eff;
    logic [ACT_DATA_WIDTH-1:0] act_mask;
    logic [WORD_WIDTH-1:0]   elem_w;

    prec_eff   = (state == IDLE) ? PRECISION : prec_q;
    e_w        = elem_width(prec_eff);
    n_el       = WORD_WIDTH / e_w;
    fill_i     = int'(fill);
    act_mask   = ACT_DATA_WIDTH'((1 << e_w) - 1);
    elem_w     = WORD_WIDTH'(in_data[ACT_DATA_WIDTH-1:0] & act_mask);
    word_next  = word_q | (elem_w << (fill_i * e_w));
    word_close = accept & (((fill_i + 1) == n_el) | in_last);
    used_bits  = (fill_i + 1) * e_w;
    strb_next  = '0;
    for (int b = 0; b < WORD_WIDTH / 8; b++) begin
      strb_next[b] = ((b * 8) < used_bits);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !word_close) state_next = PACK;
      PACK:    if (word_close) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      fill   <= '0;
      prec_q <= PREC_8B;
      word_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (state == IDLE) begin
          prec_q <= PRECISION;
        end
        if (word_close) begin
          fill   <= '0;
          word_q <= '0;
        end else begin
          fill   <= fill + FILL_ONE;
          word_q <= word_next;
        end
      end
    end
  end

  packer_word_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (word_close),
    .push_data  (word_next),
    .push_strb  (strb_next),
    .push_last  (in_last),
    .pop_ready  (out_ready),
    .pop_valid  (out_valid),
    .pop_data   (out_data),
    .pop_strb   (out_strb),
    .pop_last   (out_last),
    .full       (fifo_full)
  );

  assign busy = (fill != '0) | out_valid;

endmodule

// File: tb/tb_pe_output_packer.sv
// tb/tb_pe_output_packer.sv - self-checking bench for pe_output_packer
module tb_pe_output_packer;

  logic        clk;
  logic        reset;
  logic [1:0]  PRECISION;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } word_t;

  word_t       exp_q[$];
  word_t       obs_q[$];
  word_t       mon_w;
  int unsigned m_elems[$];
  int          m_prec;
  bit          rand_ready = 0;

  pe_output_packer dut (
    .clk       (clk),
    .reset     (reset),
    .PRECISION (PRECISION),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_strb  (out_strb),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Output handshakes are sampled late in the low phase, where they hold until the edge.
  always begin
    @(negedge clk);
    #3;
    if (!reset && out_valid && out_ready) begin
      mon_w.d = out_data;
      mon_w.s = out_strb;
      mon_w.l = out_last;
      obs_q.push_back(mon_w);
    end
  end

  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int ew(input int p);
    return (p == 0) ? 8 : ((p == 2) ? 2 : 4);
  endfunction

  // Reference: collect element values of the open word, emit the word by arithmetic.
  task automatic model_push(input int prec, input logic [31:0] d, input logic l);
    int     e;
    int     nbytes;
    longint acc;
    word_t  w;
    if (m_elems.size() == 0) m_prec = prec;
    e = ew(m_prec);
    m_elems.push_back(int'(d % (32'd1 << e)));
    if (m_elems.size() == 32 / e || l) begin
      acc = 0;
      for (int k = 0; k < m_elems.size(); k++)
        acc += longint'(m_elems[k]) * (longint'(1) << (k * e));
      nbytes = (m_elems.size() * e + 7) / 8;
      w.d = acc[31:0];
      w.s = 4'((1 << nbytes) - 1);
      w.l = l;
      exp_q.push_back(w);
      m_elems.delete();
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send_elem(input logic [31:0] d, input logic l);
    int waited = 0;
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_words(input int n, output bit ok);
    int c = 0;
    while (obs_q.size() < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic clear_all();
    exp_q.delete();
    obs_q.delete();
    m_elems.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, out_data, out_strb, out_last, busy} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%h s=%h l=%0b busy=%0b, required all 0",
               out_valid, out_data, out_strb, out_last, busy);
    end
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_pack_8b();
    logic [7:0] v [4];
    logic [31:0] held;
    bit ok;
    v = '{8'h01, 8'h02, 8'h7F, 8'h80};
    clear_all();
    PRECISION = 2'd0;
    out_ready = 0;
    for (int i = 0; i < 4; i++) send_elem({24'hABCDE0, v[i]}, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h807F0201 || out_strb !== 4'hF || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL pack_8b_word: got v=%0b d=%h s=%h l=%0b, required 1 807f0201 f 0",
               out_valid, out_data, out_strb, out_last);
    end
    held = out_data;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h807F0201) begin
      n_fail++;
      $display("FAIL pack_8b_hold: got v=%0b d=%h, required 1 807f0201 (prev %h)", out_valid, out_data, held);
    end
    out_ready = 1;
    wait_words(1, ok);
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pack_8b_count: got %0d words busy=%0b, required 1 word busy=0", obs_q.size(), busy);
    end
  endtask

  task automatic test_pack_4b_last();
    bit ok;
    clear_all();
    PRECISION = 2'd1;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) send_elem(32'(i) | 32'hF0, i == 8);
    wait_words(1, ok);
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL pack_4b_count: got %0d words, required 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].d !== 32'h87654321 || obs_q[0].s !== 4'hF || obs_q[0].l !== 1'b1) begin
        n_fail++;
        $display("FAIL pack_4b_word: got d=%h s=%h l=%0b, required 87654321 f 1",
                 obs_q[0].d, obs_q[0].s, obs_q[0].l);
      end
    end
  endtask

  task automatic test_pack_2b_partial();
    logic [1:0] v [5];
    bit ok;
    v = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clear_all();
    PRECISION = 2'd2;
    for (int i = 0; i < 5; i++) send_elem({30'h3FFFFFF0, v[i]}, i == 4);
    wait_words(1, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL pack_2b_count: got %0d words, required 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].d !== 32'h00000139 || obs_q[0].s !== 4'h3 || obs_q[0].l !== 1'b1) begin
        n_fail++;
        $display("FAIL pack_2b_word: got d=%h s=%h l=%0b, required 00000139 3 1",
                 obs_q[0].d, obs_q[0].s, obs_q[0].l);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    bit ok;
    clear_all();
    PRECISION = 2'd0;
    out_ready = 0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      send_elem(d, 1'b0);
      model_push(0, d, 1'b0);
    end
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: got in_ready=%0b busy=%0b, required 0 1", in_ready, busy);
    end
    n_checks++;
    if (out_data !== exp_q[0].d) begin
      n_fail++;
      $display("FAIL bp_head: got %h, required %h", out_data, exp_q[0].d);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      send_elem(d, 1'b0);
      model_push(0, d, 1'b0);
    end
    wait_words(5, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h/%h/%0b, required %h/%h/%0b", k,
                   obs_q[k].d, obs_q[k].s, obs_q[k].l, exp_q[k].d, exp_q[k].s, exp_q[k].l);
        end
      end
    end
  endtask

  task automatic test_mid_word_reset();
    logic [31:0] d;
    bit ok;
    clear_all();
    PRECISION = 2'd1;
    out_ready = 1;
    for (int i = 0; i < 3; i++) send_elem($urandom, 1'b0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got busy=%0b in_ready=%0b out_valid=%0b, required 0 1 0",
               busy, in_ready, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      send_elem(d, 1'b0);
      model_push(1, d, 1'b0);
    end
    wait_words(1, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL mid_reset_count: got %0d words, required 1", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL mid_reset_word: got %h/%h/%0b, required %h/%h/%0b",
                 obs_q[0].d, obs_q[0].s, obs_q[0].l, exp_q[0].d, exp_q[0].s, exp_q[0].l);
      end
    end
  endtask

  task automatic test_precision_change();
    logic [31:0] d;
    bit ok;
    clear_all();
    PRECISION = 2'd0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) PRECISION = 2'd2;
      d = $urandom;
      send_elem(d, 1'b0);
      model_push(int'(PRECISION), d, 1'b0);
    end
    wait_words(2, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL prec_change_count: got %0d words, required 2", obs_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL prec_change_word%0d: got %h/%h/%0b, required %h/%h/%0b", k,
                   obs_q[k].d, obs_q[k].s, obs_q[k].l, exp_q[k].d, exp_q[k].s, exp_q[k].l);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        l;
    bit ok;
    clear_all();
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      PRECISION = 2'($urandom_range(0, 3));
      d = $urandom;
      l = (i == 299) || ($urandom_range(0, 9) == 0);
      send_elem(d, l);
      model_push(int'(PRECISION), d, l);
    end
    rand_ready = 0;
    out_ready = 1;
    wait_words(exp_q.size(), ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != exp_q.size() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_count: got %0d words busy=%0b, required %0d busy=0",
               obs_q.size(), busy, exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random_word%0d: got %h/%h/%0b, required %h/%h/%0b", k,
                   obs_q[k].d, obs_q[k].s, obs_q[k].l, exp_q[k].d, exp_q[k].s, exp_q[k].l);
        end
      end
    end
  endtask

  initial begin
    reset     = 1;
    PRECISION = 2'd0;
    in_valid  = 0;
    in_data   = '0;
    in_last   = 0;
    out_ready = 1;
    test_reset();
    test_pack_8b();
    test_pack_4b_last();
    test_pack_2b_partial();
    test_backpressure();
    test_mid_word_reset();
    test_precision_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
